// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : RV32I data-memory responder, valid/ready request in, in-order
//               tagged responses out, with a fixed pipeline and response queue.
// Revision    : 1.0  initial release
// ============================================================================
module dmem_responder #(
  parameter int ADDR_W    = 10,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wd,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_load,
  output logic        rsp_err
);

  localparam int c_CW = $clog2(RSP_DEPTH + 1);
  localparam int c_IW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int c_QN = 2 ** c_IW;

  logic [31:0]     r_mem [2**ADDR_W];
  logic [c_CW-1:0] r_outstanding;

  logic            r_pv    [LATENCY];
  logic [4:0]      r_prd   [LATENCY];
  logic            r_pload [LATENCY];
  logic            r_perr  [LATENCY];
  logic [2:0]      r_pf3   [LATENCY];
  logic [1:0]      r_plane [LATENCY];
  logic [31:0]     r_pword [LATENCY];

  logic [31:0]     r_q_data [c_QN];
  logic [4:0]      r_q_rd   [c_QN];
  logic            r_q_load [c_QN];
  logic            r_q_err  [c_QN];
  logic [c_IW:0]   r_wp;
  logic [c_IW:0]   r_rp;

  logic              w_accept;
  logic              w_pop;
  logic              w_push;
  logic              w_illegal;
  logic              w_misal;
  logic              w_err;
  logic              w_wr_en;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_lane;
  logic [31:0]       w_lw;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_fmt;
  logic              w_unused;

  assign req_ready = !RST && (r_outstanding < c_CW'(RSP_DEPTH));
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = (r_wp != r_rp);
  assign w_pop     = rsp_valid && rsp_ready;
  assign w_push    = r_pv[LATENCY-1];
  assign w_idx     = req_addr[ADDR_W+1:2];
  assign w_lane    = req_addr[1:0];
  assign w_unused  = &{1'b0, req_addr[31:ADDR_W+2]};

  always_comb begin
    w_illegal = 1'b1;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
      3'b100, 3'b101:         w_illegal = req_we;
      default:                w_illegal = 1'b1;
    endcase
    w_misal = ((req_funct3[1:0] == 2'b01) && w_lane[0]) ||
              ((req_funct3[1:0] == 2'b10) && (w_lane != 2'b00));
    w_err   = w_illegal || w_misal;
    w_wr_en = req_we && !w_err;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = req_wd;
    case (req_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{req_wd[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wd[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = req_wd;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      if (w_wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
      r_pword[0] <= r_mem[w_idx];
    end
    for (int i = 1; i < LATENCY; i++) r_pword[i] <= r_pword[i-1];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < LATENCY; i++) r_pv[i] <= 1'b0;
    end else begin
      r_pv[0]    <= w_accept;
      r_prd[0]   <= req_rd;
      r_pload[0] <= !req_we;
      r_perr[0]  <= w_err;
      r_pf3[0]   <= req_funct3;
      r_plane[0] <= w_lane;
      for (int i = 1; i < LATENCY; i++) begin
        r_pv[i]    <= r_pv[i-1];
        r_prd[i]   <= r_prd[i-1];
        r_pload[i] <= r_pload[i-1];
        r_perr[i]  <= r_perr[i-1];
        r_pf3[i]   <= r_pf3[i-1];
        r_plane[i] <= r_plane[i-1];
      end
    end
  end

  assign w_lw = r_pword[LATENCY-1];

  always_comb begin
    w_byte = 8'(w_lw >> {r_plane[LATENCY-1], 3'b000});
    w_half = r_plane[LATENCY-1][1] ? w_lw[31:16] : w_lw[15:0];
    w_fmt  = '0;
    if (r_pload[LATENCY-1] && !r_perr[LATENCY-1]) begin
      case (r_pf3[LATENCY-1])
        3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
        3'b100:  w_fmt = {24'd0, w_byte};
        3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
        3'b101:  w_fmt = {16'd0, w_half};
        3'b010:  w_fmt = w_lw;
        default: w_fmt = '0;
      endcase
    end
  end

  // The outstanding limit guarantees the queue has room for every pipeline exit.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_q_data[r_wp[c_IW-1:0]] <= w_fmt;
      r_q_rd[r_wp[c_IW-1:0]]   <= r_prd[LATENCY-1];
      r_q_load[r_wp[c_IW-1:0]] <= r_pload[LATENCY-1];
      r_q_err[r_wp[c_IW-1:0]]  <= r_perr[LATENCY-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wp          <= '0;
      r_rp          <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign rsp_data = rsp_valid ? r_q_data[r_rp[c_IW-1:0]] : '0;
  assign rsp_rd   = rsp_valid ? r_q_rd[r_rp[c_IW-1:0]]   : '0;
  assign rsp_load = rsp_valid && r_q_load[r_rp[c_IW-1:0]];
  assign rsp_err  = rsp_valid && r_q_err[r_rp[c_IW-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wd = '0;
  logic [2:0]  req_funct3 = 3'b010;
  logic [4:0]  req_rd = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_load;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  dmem_responder #(.ADDR_W(10), .LATENCY(2), .RSP_DEPTH(4)) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wd     (req_wd),
    .req_funct3 (req_funct3),
    .req_rd     (req_rd),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_rd     (rsp_rd),
    .rsp_load   (rsp_load),
    .rsp_err    (rsp_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input logic [4:0] rd,
                        output logic [31:0] d, output logic e, output logic l,
                        output logic [4:0] r);
    req_we = we; req_addr = addr; req_wd = wd; req_funct3 = f3; req_rd = rd;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 20 && !rsp_valid; c++) tick();
    check("rsp_timeout", 32'(rsp_valid), 32'd1);
    d = rsp_data; e = rsp_err; l = rsp_load; r = rsp_rd;
    tick();
  endtask

  task automatic load_chk(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] d; logic e, l; logic [4:0] r;
    do_req(1'b0, addr, 32'd0, f3, rd, d, e, l, r);
    check({tag, "_data"}, d, exp_d);
    check({tag, "_err"}, 32'(e), 32'(exp_e));
    check({tag, "_load"}, 32'(l), 32'd1);
    check({tag, "_rd"}, 32'(r), 32'(rd));
  endtask

  task automatic store_chk(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [2:0] f3, input logic exp_e);
    logic [31:0] d; logic e, l; logic [4:0] r;
    do_req(1'b1, addr, wd, f3, 5'd0, d, e, l, r);
    check({tag, "_data"}, d, 32'd0);
    check({tag, "_err"}, 32'(e), 32'(exp_e));
    check({tag, "_load"}, 32'(l), 32'd0);
  endtask

  initial begin
    int n_acc, next_rd, got, exp_rd, n_seen;
    logic acc, pop, first;
    logic [4:0] prd, s_rd;
    logic [31:0] s_data;

    // Reset held with a pending request
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_rd = 5'd9;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_rd", 32'(rsp_rd), 32'd0);
      check("rst_rsp_load", 32'(rsp_load), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
    end
    RST = 1'b0; req_valid = 1'b0;
    #1;
    check("rst_ready_after", 32'(req_ready), 32'd1);
    n_seen = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (rsp_valid) n_seen++; end
    check("rst_no_rsp", 32'(n_seen), 32'd0);

    // Word round-trip with exact latency
    req_we = 1'b1; req_addr = 32'h10; req_wd = 32'hDEADBEEF; req_funct3 = 3'b010; req_rd = 5'd0;
    req_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    check("rt_k_valid", 32'(rsp_valid), 32'd0);
    req_we = 1'b0; req_rd = 5'd5;
    tick();
    check("rt_k1_valid", 32'(rsp_valid), 32'd0);
    req_valid = 1'b0;
    tick();
    check("rt_sw_valid", 32'(rsp_valid), 32'd1);
    check("rt_sw_load", 32'(rsp_load), 32'd0);
    check("rt_sw_err", 32'(rsp_err), 32'd0);
    check("rt_sw_data", rsp_data, 32'd0);
    check("rt_sw_rd", 32'(rsp_rd), 32'd0);
    tick();
    check("rt_lw_valid", 32'(rsp_valid), 32'd1);
    check("rt_lw_load", 32'(rsp_load), 32'd1);
    check("rt_lw_rd", 32'(rsp_rd), 32'd5);
    check("rt_lw_data", rsp_data, 32'hDEADBEEF);
    tick();
    check("rt_idle", 32'(rsp_valid), 32'd0);

    // Sub-word accesses
    store_chk("sb", 32'h11, 32'h00000080, 3'b000, 1'b0);
    load_chk("lb", 32'h11, 3'b000, 5'd1, 32'hFFFFFF80, 1'b0);
    load_chk("lbu", 32'h11, 3'b100, 5'd2, 32'h00000080, 1'b0);
    load_chk("lw_merge", 32'h10, 3'b010, 5'd3, 32'hDEAD80EF, 1'b0);
    load_chk("lh", 32'h12, 3'b001, 5'd4, 32'hFFFFDEAD, 1'b0);
    load_chk("lhu", 32'h12, 3'b101, 5'd6, 32'h0000DEAD, 1'b0);

    // Errors
    load_chk("lhu_mis", 32'h13, 3'b101, 5'd7, 32'd0, 1'b1);
    store_chk("sw_init", 32'h14, 32'h11223344, 3'b010, 1'b0);
    store_chk("sw_mis", 32'h16, 32'h12345678, 3'b010, 1'b1);
    load_chk("lw_after_mis", 32'h14, 3'b010, 5'd8, 32'h11223344, 1'b0);
    load_chk("ld_f3_011", 32'h14, 3'b011, 5'd9, 32'd0, 1'b1);
    store_chk("sb_f3_100", 32'h14, 32'h000000FF, 3'b100, 1'b1);
    load_chk("lw_after_bad_sb", 32'h14, 3'b010, 5'd10, 32'h11223344, 1'b0);

    // Backpressure: fill to the outstanding limit
    rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
    next_rd = 1; req_rd = 5'd1; req_valid = 1'b1;
    n_acc = 0; s_rd = '0; s_data = '0;
    for (int c = 0; c < 10; c++) begin
      acc = req_ready;
      tick();
      if (acc) begin n_acc++; next_rd++; req_rd = 5'(next_rd); end
      if (c == 5) begin s_rd = rsp_rd; s_data = rsp_data; end
    end
    check("bp_accepts", 32'(n_acc), 32'd4);
    check("bp_ready_full", 32'(req_ready), 32'd0);
    check("bp_valid", 32'(rsp_valid), 32'd1);
    check("bp_stable_rd", 32'(rsp_rd), 32'(s_rd));
    check("bp_stable_data", rsp_data, s_data);
    check("bp_head_rd", 32'(rsp_rd), 32'd1);
    check("bp_head_data", rsp_data, 32'hDEAD80EF);

    rsp_ready = 1'b1;
    exp_rd = 1; got = 0; first = 1'b1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      pop = rsp_valid; prd = rsp_rd; acc = req_valid && req_ready;
      tick();
      if (pop) begin
        check("bp_order", 32'(prd), 32'(exp_rd));
        exp_rd++; got++;
        if (first) begin
          check("bp_ready_after_pop", 32'(req_ready), 32'd1);
          first = 1'b0;
        end
      end
      if (acc) begin
        next_rd++;
        if (next_rd > 6) req_valid = 1'b0;
        else req_rd = 5'(next_rd);
      end
    end
    check("bp_count", 32'(got), 32'd6);
    req_valid = 1'b0;
    tick();

    // Reset while requests are in flight
    req_we = 1'b1; req_addr = 32'h20; req_wd = 32'hCAFEF00D; req_funct3 = 3'b010; req_rd = 5'd0;
    req_valid = 1'b1;
    tick();
    req_we = 1'b0; req_rd = 5'd7;
    tick();
    req_rd = 5'd8;
    tick();
    req_valid = 1'b0; RST = 1'b1;
    tick();
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    RST = 1'b0;
    n_seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (rsp_valid) n_seen++; end
    check("mid_rst_no_rsp", 32'(n_seen), 32'd0);
    load_chk("lw_after_rst", 32'h20, 3'b010, 5'd3, 32'hCAFEF00D, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
